// File: rtl/flappy_scene.sv
// flappy_scene: bird/pipe game state stepped once per frame plus registered pixel colour (optional FLAPPY_SCORE_BAR_EN score bar)
module flappy_scene #(
    parameter int GRAVITY = 1,
    parameter int FLAP_V = 8,
    parameter int MAX_FALL = 10,
    parameter int SPEED = 2,
    parameter int GAP = 128,
    parameter int BIRD_X = 160,
    parameter int BIRD_Y0 = 232,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flap,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        dat_act,
    output logic [11:0] rgb,
    output logic [7:0]  score,
    output logic        game_over
);
    typedef enum logic [1:0] {READY, PLAY, DEAD} state_t;
    localparam logic signed [10:0] BX = 11'(BIRD_X);
    localparam logic signed [10:0] BY0 = 11'(BIRD_Y0);
    localparam logic signed [10:0] GAPS = 11'(GAP);
    localparam logic [9:0] GAP0 = 10'd48 + {2'b0, LFSR_SEED};

    state_t state, state_nx;
    logic [2:0] sync;
    logic flap_edge, flap_pend, vc_end_q, tick, hit, wrap, bird_px, pipe_px, bar_px;
    logic [7:0] lfsr, score_nx;
    logic [9:0] gap_top, gap_nx;
    logic signed [5:0] vel, vel_nx;
    logic signed [6:0] vel_g;
    logic signed [10:0] bird_y, pipe_x, y_nx, px_dec, px_nx, gap_lo, gap_hi, hc_s, vc_s, pg_lo;

    assign tick = vc == 10'd480 && !vc_end_q;
    assign game_over = state == DEAD;

    // flap synchroniser, registered rising-edge detect and frame-end history
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            flap_edge <= 1'b0;
            vc_end_q <= 1'b0;
        end else begin
            sync <= {sync[1:0], flap};
            flap_edge <= sync[1] & ~sync[2];
            vc_end_q <= vc == 10'd480;
        end
    end

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, keeps running across restarts
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else if (tick) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // game state register
    always_ff @(posedge clk) begin
        if (reset) state <= READY;
        else state <= state_nx;
    end

    // game transitions: flap starts and restarts, a fatal tick kills
    always_comb begin
        state_nx = state;
        if (state == READY && flap_edge) state_nx = PLAY;
        else if (state == PLAY && tick && hit) state_nx = DEAD;
        else if (state == DEAD && flap_edge) state_nx = READY;
    end

    // one PLAY tick of physics and scrolling; collision is judged on the updated values
    always_comb begin
        vel_g = 7'(vel) + 7'(GRAVITY);
        vel_nx = (flap_pend | flap_edge) ? -6'(FLAP_V) : (vel_g > 7'(MAX_FALL)) ? 6'(MAX_FALL) : vel_g[5:0];
        y_nx = bird_y + 11'(vel_nx);
        px_dec = pipe_x - 11'(SPEED);
        wrap = px_dec <= -11'sd64;
        px_nx = wrap ? 11'sd640 : px_dec;
        gap_nx = wrap ? 10'd48 + {2'b0, lfsr} : gap_top;
        score_nx = (wrap && score != 8'hFF) ? score + 8'd1 : score;
        gap_lo = $signed({1'b0, gap_nx});
        gap_hi = gap_lo + GAPS;
        hit = y_nx[10] || y_nx + 11'sd15 >= 11'sd464 ||
              (px_nx <= BX + 11'sd15 && px_nx + 11'sd63 >= BX && (y_nx < gap_lo || y_nx + 11'sd15 >= gap_hi));
    end

    // bird, pipe and score: initialised on reset or restart, stepped on PLAY ticks
    always_ff @(posedge clk) begin
        if (reset || (state == DEAD && flap_edge)) begin
            bird_y <= BY0;
            vel <= '0;
            pipe_x <= 11'sd640;
            gap_top <= GAP0;
            score <= '0;
            flap_pend <= 1'b0;
        end else if (state == PLAY && tick) begin
            bird_y <= y_nx;
            vel <= vel_nx;
            pipe_x <= px_nx;
            gap_top <= gap_nx;
            score <= score_nx;
            flap_pend <= 1'b0;
        end else if (state == PLAY && flap_edge) begin
            flap_pend <= 1'b1;
        end
    end

    // per-pixel object membership
    always_comb begin
        hc_s = $signed({1'b0, hc});
        vc_s = $signed({1'b0, vc});
        pg_lo = $signed({1'b0, gap_top});
        bird_px = hc_s >= BX && hc_s <= BX + 11'sd15 && vc_s >= bird_y && vc_s <= bird_y + 11'sd15;
        pipe_px = hc_s >= pipe_x && hc_s <= pipe_x + 11'sd63 && (vc_s < pg_lo || vc_s >= pg_lo + GAPS);
`ifdef FLAPPY_SCORE_BAR_EN
        bar_px = vc < 10'd8 && hc < {1'b0, score, 1'b0};
`else
        bar_px = 1'b0;
`endif
    end

    // colour priority: bird, score bar, pipe, ground, sky
    always_ff @(posedge clk) begin
        if (reset) rgb <= '0;
        else rgb <= !dat_act ? 12'h000 : bird_px ? 12'hFF0 : bar_px ? 12'hFFF :
                    pipe_px ? 12'h0C0 : vc >= 10'd464 ? 12'h850 : 12'h4AF;
    end
endmodule

// File: tb/tb_flappy_scene.sv
// tb_flappy_scene: scenario tasks checked against an integer-arithmetic game model
module tb_flappy_scene;
    logic clk = 0, reset = 1, flap = 0, dat_act = 0;
    logic [9:0] hc = 0, vc = 0;
    logic [11:0] rgb;
    logic [7:0] score;
    logic game_over;
    int pass_cnt = 0, total_cnt = 0;
    int m_st, m_y, m_v, m_px, m_gap, m_score, m_lfsr, m_pend;

    flappy_scene dut (.clk(clk), .reset(reset), .flap(flap), .hc(hc), .vc(vc), .dat_act(dat_act),
                      .rgb(rgb), .score(score), .game_over(game_over));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_st = 0; m_y = 232; m_v = 0; m_px = 640; m_gap = 48 + 'hA5; m_score = 0; m_lfsr = 'hA5; m_pend = 0;
    endfunction

    function automatic void model_flap();
        if (m_st == 0) m_st = 1;
        else if (m_st == 1) m_pend = 1;
        else begin
            m_st = 0; m_y = 232; m_v = 0; m_px = 640; m_gap = 48 + 'hA5; m_score = 0; m_pend = 0;
        end
    endfunction

    function automatic void model_tick();
        int old = m_lfsr;
        int fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
        if (m_st != 1) return;
        m_v = m_pend ? -8 : (m_v + 1 > 10 ? 10 : m_v + 1);
        m_pend = 0;
        m_y += m_v;
        m_px -= 2;
        if (m_px <= -64) begin
            m_px = 640;
            m_gap = 48 + old;
            if (m_score < 255) m_score++;
        end
        if (m_y + 15 >= 464 || m_y < 0 ||
            (m_px <= 175 && m_px + 63 >= 160 && (m_y < m_gap || m_y + 15 >= m_gap + 128))) m_st = 2;
    endfunction

    function automatic int colour(int h, int v, bit act);
        if (!act) return 0;
        if (h >= 160 && h <= 175 && v >= m_y && v <= m_y + 15) return 'hFF0;
`ifdef FLAPPY_SCORE_BAR_EN
        if (v < 8 && h < 2 * m_score) return 'hFFF;
`endif
        if (h >= m_px && h <= m_px + 63 && (v < m_gap || v >= m_gap + 128)) return 'h0C0;
        if (v >= 464) return 'h850;
        return 'h4AF;
    endfunction

    task automatic do_reset();
        reset = 1; flap = 0; vc = 0; dat_act = 0;
        cyc(1);
        reset = 0;
        model_reset();
    endtask

    task automatic frame(input bit f);
        flap = f; vc = 0;
        cyc(5);
        flap = 0; vc = 10'd480;
        cyc(1);
        vc = 0;
        cyc(1);
        if (f) model_flap();
        model_tick();
    endtask

    task automatic pixel(input int h, input int v, input bit act);
        hc = 10'(h); vc = 10'(v); dat_act = act;
        cyc(1);
    endtask

    task automatic test_reset();
        int exp_px [4] = '{'hFF0, 'h4AF, 'h850, 'h000};
        int ph [4] = '{160, 0, 0, 0};
        int pv [4] = '{232, 100, 470, 100};
        do_reset();
        total_cnt++; if (rgb !== 12'h000 || score !== 8'd0 || game_over !== 1'b0)
            $display("FAIL reset_outputs rgb=%h score=%0d go=%b want 000/0/0", rgb, score, game_over); else pass_cnt++;
        total_cnt++; if (int'(dut.bird_y) !== 232 || int'(dut.pipe_x) !== 640 || int'(dut.gap_top) !== 213)
            $display("FAIL reset_state y=%0d px=%0d gap=%0d want 232/640/213", dut.bird_y, dut.pipe_x, dut.gap_top); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            pixel(ph[i], pv[i], i != 3);
            total_cnt++; if (int'(rgb) !== exp_px[i] || int'(rgb) !== colour(ph[i], pv[i], i != 3))
                $display("FAIL ready_pixel%0d got %h want %h", i, rgb, exp_px[i]); else pass_cnt++;
        end
    endtask

    task automatic test_free_fall();
        int x_px;
        do_reset();
        frame(1);
        for (int t = 2; t <= 27; t++) begin
            frame(0);
            if (t == 10) begin
                total_cnt++; if (int'(dut.bird_y) !== 287 || int'(dut.vel) !== 10)
                    $display("FAIL fall_tick10 y=%0d vel=%0d want 287/10", dut.bird_y, dut.vel); else pass_cnt++;
            end
            if (t == 26) begin
                total_cnt++; if (game_over !== 1'b0) $display("FAIL fall_alive26 got %b want 0", game_over); else pass_cnt++;
            end
        end
        total_cnt++; if (game_over !== 1'b1 || int'(dut.bird_y) !== 457 || score !== 8'd0 || m_st != 2)
            $display("FAIL fall_dead go=%b y=%0d score=%0d want 1/457/0", game_over, dut.bird_y, score); else pass_cnt++;
        x_px = int'(dut.pipe_x);
        frame(0);
        frame(0);
        total_cnt++; if (int'(dut.bird_y) !== 457 || int'(dut.pipe_x) !== m_px || game_over !== 1'b1)
            $display("FAIL dead_frozen y=%0d px=%0d (was %0d) want 457/%0d", dut.bird_y, dut.pipe_x, x_px, m_px); else pass_cnt++;
    endtask

    task automatic test_restart();
        frame(1);
        total_cnt++; if (game_over !== 1'b0 || score !== 8'd0 || int'(dut.bird_y) !== 232 || int'(dut.pipe_x) !== 640 || m_st != 0)
            $display("FAIL restart go=%b score=%0d y=%0d px=%0d want 0/0/232/640", game_over, score, dut.bird_y, dut.pipe_x); else pass_cnt++;
        total_cnt++; if (int'(dut.lfsr) !== m_lfsr)
            $display("FAIL restart_lfsr got %h want %h", dut.lfsr, m_lfsr); else pass_cnt++;
    endtask

    task automatic test_coincide();
        int y0, n = 0;
        frame(1);
        while (m_v != 3 && n < 10) begin frame(0); n++; end
        y0 = m_y;
        flap = 1; vc = 0;
        cyc(3);
        vc = 10'd480;
        cyc(1);
        flap = 0; vc = 0;
        cyc(1);
        model_flap();
        model_tick();
        total_cnt++; if (int'(dut.vel) !== -8 || int'(dut.bird_y) !== y0 - 8 || m_y != y0 - 8)
            $display("FAIL coincide vel=%0d y=%0d want -8/%0d", dut.vel, dut.bird_y, y0 - 8); else pass_cnt++;
        frame(0);
        total_cnt++; if (int'(dut.vel) !== -7 || int'(dut.bird_y) !== m_y)
            $display("FAIL coincide_once vel=%0d y=%0d want -7/%0d", dut.vel, dut.bird_y, m_y); else pass_cnt++;
    endtask

    task automatic test_scoring();
        int bad = 0;
        do_reset();
        frame(1);
        for (int t = 2; t <= 352; t++) begin
            frame(m_y > m_gap + 48);
            if (bad < 3 && (int'(dut.bird_y) !== m_y || int'(dut.pipe_x) !== m_px)) begin
                bad++;
                $display("FAIL score_track t=%0d y=%0d px=%0d want %0d/%0d", t, dut.bird_y, dut.pipe_x, m_y, m_px);
            end
        end
        total_cnt++; if (bad == 0) pass_cnt++;
        total_cnt++; if (score !== 8'd1 || int'(dut.pipe_x) !== 640 || int'(dut.gap_top) !== m_gap || game_over !== 1'b0 || m_score != 1)
            $display("FAIL score_respawn score=%0d px=%0d gap=%0d go=%b want 1/640/%0d/0", score, dut.pipe_x, dut.gap_top, game_over, m_gap); else pass_cnt++;
`ifdef FLAPPY_SCORE_BAR_EN
        pixel(1, 3, 1);
        total_cnt++; if (rgb !== 12'hFFF) $display("FAIL bar_in got %h want fff", rgb); else pass_cnt++;
        pixel(2, 3, 1);
        total_cnt++; if (rgb !== 12'h4AF) $display("FAIL bar_out got %h want 4af", rgb); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        pixel(0, 100, 1);
        total_cnt++; if (rgb !== 12'h4AF) $display("FAIL pre_reset_sky got %h want 4af", rgb); else pass_cnt++;
        reset = 1;
        cyc(1);
        total_cnt++; if (rgb !== 12'h000 || score !== 8'd0 || game_over !== 1'b0)
            $display("FAIL midreset_outputs rgb=%h score=%0d go=%b want 000/0/0", rgb, score, game_over); else pass_cnt++;
        total_cnt++; if (int'(dut.bird_y) !== 232 || int'(dut.vel) !== 0 || int'(dut.pipe_x) !== 640 || int'(dut.lfsr) !== 'hA5 || int'(dut.gap_top) !== 213)
            $display("FAIL midreset_state y=%0d vel=%0d px=%0d lfsr=%h gap=%0d", dut.bird_y, dut.vel, dut.pipe_x, dut.lfsr, dut.gap_top); else pass_cnt++;
        reset = 0;
        model_reset();
        frame(0);
        total_cnt++; if (int'(dut.bird_y) !== 232 || game_over !== 1'b0)
            $display("FAIL midreset_ready y=%0d go=%b want 232/0", dut.bird_y, game_over); else pass_cnt++;
    endtask

    task automatic test_random();
        int h, v, mode, bad_s = 0, bad_p = 0;
        bit act;
        do_reset();
        for (int f = 0; f < 200; f++) begin
            frame($urandom_range(0, 2) == 0);
            if (bad_s < 3 && (int'(dut.bird_y) !== m_y || int'(dut.vel) !== m_v || int'(dut.pipe_x) !== m_px ||
                              int'(score) !== m_score || game_over !== (m_st == 2))) begin
                bad_s++;
                $display("FAIL rand_state f=%0d y=%0d v=%0d px=%0d sc=%0d go=%b want %0d/%0d/%0d/%0d/%0d",
                         f, dut.bird_y, dut.vel, dut.pipe_x, score, game_over, m_y, m_v, m_px, m_score, m_st == 2);
            end
            mode = int'($urandom_range(0, 2));
            h = (mode == 1) ? 150 + int'($urandom_range(0, 35)) : (mode == 2) ? m_px - 4 + int'($urandom_range(0, 71)) : int'($urandom_range(0, 639));
            v = (mode == 1) ? m_y - 4 + int'($urandom_range(0, 23)) : int'($urandom_range(0, 479));
            if (h < 0) h = 0;
            if (h > 639) h = 639;
            if (v < 0) v = 0;
            if (v > 479) v = 479;
            act = $urandom_range(0, 7) != 0;
            pixel(h, v, act);
            if (bad_p < 3 && int'(rgb) !== colour(h, v, act)) begin
                bad_p++;
                $display("FAIL rand_pixel (%0d,%0d,%b) got %h want %h", h, v, act, rgb, colour(h, v, act));
            end
        end
        total_cnt++; if (bad_s == 0) pass_cnt++;
        total_cnt++; if (bad_p == 0) pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_free_fall();
        test_restart();
        test_coincide();
        test_scoring();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
